// File: rtl/mprj_io_cfg_pkg.sv
// Shared types and constants for the user-area GPIO configuration sequencer.
package mprj_io_cfg_pkg;

    // Transfer sequencing states
    typedef enum logic [2:0] {
        StIdle,
        StCrst,
        StShift,
        StLoad,
        StFin
    } cfg_state_e;

    // Power-on pad configuration: default input mode
    localparam logic [12:0] CFG_DEFAULT = 13'h0403;

    // Serial bits per transfer: the longer chain sets the length
    function automatic int unsigned shift_len(input int unsigned a, input int unsigned b,
                                              input int unsigned w);
        return ((a > b) ? a : b) * w;
    endfunction

endpackage

// File: rtl/mprj_io_cfg_clkgen.sv
// Serial clock divider: a CLK_DIV-cycle period counter giving the phase for the next
// cycle (low for the first half, high for the second) and a tick on the last cycle.
module mprj_io_cfg_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic restart,
    output logic tick,
    output logic next_phase
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: held at zero when disabled or restarted, wraps at end of period
    always_comb begin
        cnt_d = cnt_q;
        if (restart || !en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick       = en && !restart && (cnt_q == CNT_LAST);
    assign next_phase = en && !restart && (cnt_d >= CNT_HALF);

    // Period counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mprj_io_cfg_sequencer.sv
// GPIO configuration sequencer: holds one configuration word per user pad and, on
// request, resets both serial chains, shifts them in parallel and pulses the load.
// Optional: define MPRJ_IO_CFG_AUTOSTART_EN to launch one transfer automatically
// on the second cycle after reset release.
module mprj_io_cfg_sequencer
    import mprj_io_cfg_pkg::*;
#(
    parameter int unsigned AREA1PADS  = 19,
    parameter int unsigned TOTAL_PADS = 38,
    parameter int unsigned CFG_WIDTH  = 13,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_addr,
    input  logic [CFG_WIDTH-1:0] cfg_wdata,
    output logic [CFG_WIDTH-1:0] cfg_rdata,
    input  logic                 xfer_start,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_err,
    input  logic                 err_clr,
    output logic                 serial_resetn,
    output logic                 serial_clock,
    output logic                 serial_load,
    output logic                 serial_data_1,
    output logic                 serial_data_2
);

    localparam int unsigned N    = shift_len(AREA1PADS, TOTAL_PADS - AREA1PADS, CFG_WIDTH);
    localparam int unsigned BW   = $clog2(N + 1);
    localparam int unsigned WW   = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
    // Leading zero bits so the shorter chain ends on the same bit as the longer one
    localparam int unsigned PRE1 = N - AREA1PADS * CFG_WIDTH;
    localparam int unsigned PRE2 = N - (TOTAL_PADS - AREA1PADS) * CFG_WIDTH;

    localparam logic [5:0]    PAD1_FIRST = 6'(AREA1PADS - 1);
    localparam logic [5:0]    PAD2_FIRST = 6'(TOTAL_PADS - 1);
    localparam logic [WW-1:0] WBIT_TOP   = WW'(CFG_WIDTH - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(N);

    cfg_state_e state_q, state_d;

    logic [CFG_WIDTH-1:0] shadow_q [TOTAL_PADS];

    // Cursor: bit_q counts bits already presented; per-chain pad and bit-in-word
    logic [BW-1:0] bit_q, bit_d;
    logic [5:0]    pad1_q, pad1_d, pad2_q, pad2_d;
    logic [WW-1:0] wbit1_q, wbit1_d, wbit2_q, wbit2_d;

    logic busy_q, done_q, wr_err_q;
    logic sresetn_q, sclock_q, sload_q, sdata1_q, sdata2_q;

    logic start, tick, next_phase, load_bit;
    logic act1, act2, bit1, bit2;
    logic addr_ok, wr_ok;

    mprj_io_cfg_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk        (clk),
        .resetn     (resetn),
        .en         (busy_q),
        .restart    (state_q == StIdle),
        .tick       (tick),
        .next_phase (next_phase)
    );

`ifdef MPRJ_IO_CFG_AUTOSTART_EN
    logic [1:0] auto_q;

    // Counts cycles after reset release; value 2 marks the auto-launch cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            auto_q <= 2'd0;
        end else if (auto_q != 2'd3) begin
            auto_q <= auto_q + 2'd1;
        end
    end

    assign start = xfer_start || (auto_q == 2'd2);
`else
    assign start = xfer_start;
`endif

    assign addr_ok   = (cfg_addr < 6'(TOTAL_PADS));
    assign wr_ok     = cfg_we && !busy_q && addr_ok;
    assign cfg_rdata = addr_ok ? shadow_q[cfg_addr] : '0;

    assign act1 = (int'(bit_q) >= int'(PRE1));
    assign act2 = (int'(bit_q) >= int'(PRE2));
    assign bit1 = act1 ? shadow_q[pad1_q][wbit1_q] : 1'b0;
    assign bit2 = act2 ? shadow_q[pad2_q][wbit2_q] : 1'b0;

    // Next state and cursor advance; load_bit marks the start of a bit's low phase
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        pad1_d   = pad1_q;
        pad2_d   = pad2_q;
        wbit1_d  = wbit1_q;
        wbit2_d  = wbit2_q;
        load_bit = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCrst;
                    bit_d   = '0;
                    pad1_d  = PAD1_FIRST;
                    pad2_d  = PAD2_FIRST;
                    wbit1_d = WBIT_TOP;
                    wbit2_d = WBIT_TOP;
                end
            end
            StCrst: begin
                if (tick) begin
                    state_d  = StShift;
                    load_bit = 1'b1;
                end
            end
            StShift: begin
                if (tick) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = StLoad;
                    end else begin
                        load_bit = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (tick) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load_bit) begin
            bit_d = bit_q + 1'b1;
            if (act1) begin
                if (wbit1_q == '0) begin
                    wbit1_d = WBIT_TOP;
                    pad1_d  = pad1_q - 1'b1;
                end else begin
                    wbit1_d = wbit1_q - 1'b1;
                end
            end
            if (act2) begin
                if (wbit2_q == '0) begin
                    wbit2_d = WBIT_TOP;
                    pad2_d  = pad2_q - 1'b1;
                end else begin
                    wbit2_d = wbit2_q - 1'b1;
                end
            end
        end
    end

    // State, cursor and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            bit_q     <= '0;
            pad1_q    <= '0;
            pad2_q    <= '0;
            wbit1_q   <= '0;
            wbit2_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sresetn_q <= 1'b0;
            sclock_q  <= 1'b0;
            sload_q   <= 1'b0;
            sdata1_q  <= 1'b0;
            sdata2_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            pad1_q    <= pad1_d;
            pad2_q    <= pad2_d;
            wbit1_q   <= wbit1_d;
            wbit2_q   <= wbit2_d;
            busy_q    <= state_d inside {StCrst, StShift, StLoad};
            done_q    <= (state_d == StFin);
            sresetn_q <= (state_d != StCrst);
            sclock_q  <= (state_d == StShift) && next_phase;
            sload_q   <= (state_d == StLoad);
            if (load_bit) begin
                sdata1_q <= bit1;
                sdata2_q <= bit2;
            end else if (state_d == StCrst) begin
                sdata1_q <= 1'b0;
                sdata2_q <= 1'b0;
            end
        end
    end

    // Shadow register file; writes are only taken while idle and in range
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < TOTAL_PADS; i++) begin
                shadow_q[i] <= CFG_WIDTH'(CFG_DEFAULT);
            end
        end else if (wr_ok) begin
            shadow_q[cfg_addr] <= cfg_wdata;
        end
    end

    // Sticky write-reject flag; clear wins over a same-cycle set
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_err_q <= 1'b0;
        end else if (err_clr) begin
            wr_err_q <= 1'b0;
        end else if (cfg_we && !wr_ok) begin
            wr_err_q <= 1'b1;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign wr_err        = wr_err_q;
    assign serial_resetn = sresetn_q;
    assign serial_clock  = sclock_q;
    assign serial_load   = sload_q;
    assign serial_data_1 = sdata1_q;
    assign serial_data_2 = sdata2_q;

endmodule

// File: tb/tb_mprj_io_cfg_sequencer.sv
// Directed bench for mprj_io_cfg_sequencer: reset values, register port, full
// transfer bit streams and timing, write rejection, and abort by reset.
module tb_mprj_io_cfg_sequencer;

    localparam int A1  = 19;
    localparam int TOT = 38;
    localparam int W   = 13;
    localparam int NB  = 247;   // max(19,19)*13
    localparam int LAT = 998;   // start cycle through done cycle, inclusive

    logic        clk = 1'b0;
    logic        resetn, cfg_we, xfer_start, err_clr;
    logic [5:0]  cfg_addr;
    logic [12:0] cfg_wdata, cfg_rdata;
    logic        busy, done, wr_err;
    logic        serial_resetn, serial_clock, serial_load, serial_data_1, serial_data_2;

    always #5 clk = ~clk;

    mprj_io_cfg_sequencer #(
        .AREA1PADS  (A1),
        .TOTAL_PADS (TOT),
        .CFG_WIDTH  (W),
        .CLK_DIV    (4)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_rdata     (cfg_rdata),
        .xfer_start    (xfer_start),
        .busy          (busy),
        .done          (done),
        .wr_err        (wr_err),
        .err_clr       (err_clr),
        .serial_resetn (serial_resetn),
        .serial_clock  (serial_clock),
        .serial_load   (serial_load),
        .serial_data_1 (serial_data_1),
        .serial_data_2 (serial_data_2)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [12:0] model [TOT];
    bit          cap1 [$];
    bit          cap2 [$];
    int          sclk_rises = 0;
    int          load_cycles = 0;
    int          done_pulses = 0;
    int          data_viol = 0;
    logic        prev_d1 = 1'b0;
    logic        prev_d2 = 1'b0;

    // Chain data captured on every rising serial clock
    always @(posedge serial_clock) begin
        cap1.push_back(serial_data_1);
        cap2.push_back(serial_data_2);
        sclk_rises++;
    end

    // Load/done cycle counts and data changes seen during the high phase
    always @(negedge clk) begin
        if (resetn) begin
            if (serial_load) load_cycles++;
            if (done) done_pulses++;
            if (serial_clock && (serial_data_1 !== prev_d1 || serial_data_2 !== prev_d2))
                data_viol++;
        end
        prev_d1 = serial_data_1;
        prev_d2 = serial_data_2;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [12:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < TOT; i++) model[i] = 13'h0403;
    endtask

    task automatic start_xfer(output int cyc);
        xfer_start = 1'b1;
        cyc = 1;
        step();
        cyc++;
        xfer_start = 1'b0;
    endtask

    task automatic wait_done(inout int cyc);
        while (done !== 1'b1 && cyc < 2000) begin
            step();
            cyc++;
        end
    endtask

    // Expected chain bit b: chain 1 sends pad 18..0, chain 2 pad 37..19, MSB first
    function automatic bit exp_bit(input int chain, input int b);
        int len, pre, j, pad, pos;
        len = (chain == 1) ? A1 : TOT - A1;
        pre = NB - len * W;
        if (b < pre) return 1'b0;
        j   = b - pre;
        pad = ((chain == 1) ? A1 - 1 : TOT - 1) - j / W;
        pos = W - 1 - j % W;
        return model[pad][pos];
    endfunction

    function automatic logic [12:0] cap_word(input int chain, input int start);
        logic [12:0] v = '0;
        for (int i = 0; i < W; i++) v = {v[11:0], (chain == 1) ? cap1[start + i] : cap2[start + i]};
        return v;
    endfunction

    task automatic check_stream(input int base, input string tag);
        int m1 = 0;
        int m2 = 0;
        if (cap1.size() - base != NB || cap2.size() - base != NB) begin
            m1 = NB;
            m2 = NB;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (cap1[base + b] != exp_bit(1, b)) m1++;
                if (cap2[base + b] != exp_bit(2, b)) m2++;
            end
        end
        check_eq({tag, "_chain1_bad_bits"}, m1, 0);
        check_eq({tag, "_chain2_bad_bits"}, m2, 0);
    endtask

    initial begin
        int cyc, base, r0, l0, d0, v0, g;

        resetn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        xfer_start = 1'b0; err_clr = 1'b0;
        model_reset();
        step();
        step();

        // Reset values
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_wr_err", wr_err, 0);
        check_eq("rst_serial_resetn", serial_resetn, 0);
        check_eq("rst_serial_clk_load_data",
                 {serial_clock, serial_load, serial_data_1, serial_data_2}, 0);
        cfg_addr = 6'd0;  #1;
        check_eq("rst_rdata_pad0", cfg_rdata, 13'h0403);
        cfg_addr = 6'd37; #1;
        check_eq("rst_rdata_pad37", cfg_rdata, 13'h0403);

        resetn = 1'b1;
        #1;
        check_eq("release_serial_resetn_before_edge", serial_resetn, 0);
        step();
        check_eq("release_serial_resetn_after_edge", serial_resetn, 1);

`ifdef MPRJ_IO_CFG_AUTOSTART_EN
        // Launch cycle is the one after edge 2, so done shows after edge 2+997
        cyc = 1;
        while (done !== 1'b1 && cyc < 2000) begin
            step();
            cyc++;
        end
        check_eq("autostart_latency_edges", cyc, 999);
        step();
        check_eq("autostart_done_one_cycle", done, 0);
`else
        repeat (4) step();
        check_eq("no_autostart_busy", busy, 0);
        check_eq("no_autostart_done_pulses", done_pulses, 0);
`endif

        // Idle writes
        wr(6'd0, 13'h1ABC);  model[0]  = 13'h1ABC;
        wr(6'd18, 13'h0001); model[18] = 13'h0001;
        wr(6'd37, 13'h1FFF); model[37] = 13'h1FFF;
        check_eq("idle_wr_no_err", wr_err, 0);
        cfg_addr = 6'd0; #1;
        check_eq("rd_pad0", cfg_rdata, 13'h1ABC);
        cfg_addr = 6'd18; #1;
        check_eq("rd_pad18", cfg_rdata, 13'h0001);

        // Transfer 1, with busy-time write handling exercised along the way
        base = cap1.size(); r0 = sclk_rises; l0 = load_cycles; d0 = done_pulses; v0 = data_viol;
        start_xfer(cyc);
        check_eq("x1_busy", busy, 1);
        check_eq("x1_crst_serial_resetn", serial_resetn, 0);
        cfg_we = 1'b1; cfg_addr = 6'd3; cfg_wdata = 13'h0555;
        step(); cyc++;
        cfg_we = 1'b0;
        check_eq("busy_wr_err_set", wr_err, 1);
        check_eq("busy_wr_shadow_kept", cfg_rdata, 13'h0403);
        xfer_start = 1'b1;
        step(); cyc++;
        xfer_start = 1'b0;
        err_clr = 1'b1;
        step(); cyc++;
        err_clr = 1'b0;
        check_eq("err_clr", wr_err, 0);
        cfg_we = 1'b1; err_clr = 1'b1;
        step(); cyc++;
        cfg_we = 1'b0; err_clr = 1'b0;
        check_eq("err_set_and_clr", wr_err, 0);
        wait_done(cyc);
        check_eq("x1_latency", cyc, LAT);
        step();
        check_eq("x1_done_one_cycle", {busy, done}, 0);
        check_eq("x1_done_pulses", done_pulses - d0, 1);
        check_eq("x1_load_cycles", load_cycles - l0, 4);
        check_eq("x1_sclk_rises", sclk_rises - r0, NB);
        check_eq("x1_data_change_in_high", data_viol - v0, 0);
        if (cap1.size() - base == NB && cap2.size() - base == NB) begin
            check_eq("x1_chain1_first_word", cap_word(1, base), 13'h0001);
            check_eq("x1_chain1_last_word", cap_word(1, base + NB - W), 13'h1ABC);
            check_eq("x1_chain2_first_word", cap_word(2, base), 13'h1FFF);
        end
        check_stream(base, "x1");

        // Out-of-range writes, including the first invalid index
        wr(6'd40, 13'h1111);
        check_eq("oor40_wr_err", wr_err, 1);
        cfg_addr = 6'd40; #1;
        check_eq("oor40_rdata", cfg_rdata, 0);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        wr(6'd38, 13'h1111);
        check_eq("oor38_wr_err", wr_err, 1);
        cfg_addr = 6'd38; #1;
        check_eq("oor38_rdata", cfg_rdata, 0);
        err_clr = 1'b1; step(); err_clr = 1'b0;

        // Abort by reset at bit 100
        wr(6'd19, 13'h1234); model[19] = 13'h1234;
        l0 = load_cycles; d0 = done_pulses; r0 = sclk_rises;
        start_xfer(cyc);
        g = 0;
        while (sclk_rises - r0 < 100 && g < 2000) begin
            step();
            g++;
        end
        check_eq("abort_reach_bit100", sclk_rises - r0, 100);
        resetn = 1'b0;
        #1;
        check_eq("abort_busy_done", {busy, done}, 0);
        check_eq("abort_serial", {serial_resetn, serial_clock, serial_load}, 0);
        model_reset();
        step();
        step();
        resetn = 1'b1;
        step();
        check_eq("abort_no_load", load_cycles - l0, 0);
        check_eq("abort_no_done", done_pulses - d0, 0);
        cfg_addr = 6'd19; #1;
        check_eq("abort_shadow_reset", cfg_rdata, 13'h0403);

`ifdef MPRJ_IO_CFG_AUTOSTART_EN
        g = 0;
        while (done !== 1'b1 && g < 2000) begin
            step();
            g++;
        end
        step();
`endif

        // Fresh transfer after abort, patterns on both chains
        wr(6'd19, 13'h1234); model[19] = 13'h1234;
        wr(6'd10, 13'h0F0F); model[10] = 13'h0F0F;
        base = cap1.size(); l0 = load_cycles; r0 = sclk_rises;
        start_xfer(cyc);
        wait_done(cyc);
        check_eq("x2_latency", cyc, LAT);
        check_eq("x2_sclk_rises", sclk_rises - r0, NB);
        check_eq("x2_load_cycles", load_cycles - l0, 4);
        if (cap2.size() - base == NB) begin
            check_eq("x2_chain2_last_word", cap_word(2, base + NB - W), 13'h1234);
        end
        check_stream(base, "x2");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mprj_io_cfg_sequencer.md
Name: mprj_io_cfg_sequencer

Overview:
Sequences loading of per-pad GPIO configuration words into the two serial configuration chains that drive the user-area pad controls (area 1 and area 2).
- Holds a shadow register file of one CFG_WIDTH word per pad, written and read over a simple register port.
- On a start strobe it resets the chains, shifts both chains in parallel on a divided serial clock, then pulses a load strobe.
- Sits between housekeeping registers and the per-pad control blocks feeding the pad array.

Parameters:
AREA1PADS, 19, pads on chain 1 (pad indices 0..AREA1PADS-1)
TOTAL_PADS, 38, total user pads; chain 2 covers AREA1PADS..TOTAL_PADS-1
CFG_WIDTH, 13, bits per pad configuration word
CLK_DIV, 4, clk cycles per serial_clock period; even, >=2

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
cfg_we  input  1  write strobe, one cycle
cfg_addr  input  6  pad index
cfg_wdata  input  CFG_WIDTH  write data
cfg_rdata  output  CFG_WIDTH  shadow word at cfg_addr, combinational
xfer_start  input  1  start-transfer strobe
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at transfer end
wr_err  output  1  sticky; write rejected (busy or address >= TOTAL_PADS)
err_clr  input  1  clears wr_err
serial_resetn  output  1  active-low chain reset
serial_clock  output  1  chain shift clock
serial_load  output  1  chain load strobe
serial_data_1  output  1  chain 1 data
serial_data_2  output  1  chain 2 data

Behaviour:
- Reset: all shadow words = 13'h0403 (default input mode). Output reset values:
  - busy=0, done=0, wr_err=0
  - serial_resetn=0 (asserted), serial_clock=0, serial_load=0, serial_data_*=0
- First cycle after reset release: serial_resetn goes to 1 while idle.
- Writes:
  - Accepted only when busy=0 and cfg_addr<TOTAL_PADS. Shadow word updates on the same edge.
  - Otherwise the write is dropped and wr_err is set.
  - err_clr has priority over a same-cycle set.
- cfg_rdata: returns 0 for out-of-range addresses.
- FSM states: IDLE, CRST, SHIFT, LOAD, FIN.
  - IDLE: xfer_start -> CRST, busy=1. xfer_start while busy is ignored.
  - CRST: serial_resetn=0 for CLK_DIV cycles -> SHIFT.
  - SHIFT: N = max(AREA1PADS, TOTAL_PADS-AREA1PADS)*CFG_WIDTH serial bits. Per bit, serial_clock is low CLK_DIV/2 cycles, then high CLK_DIV/2 cycles. serial_data_* changes only at the start of the low phase. After bit N's high phase -> LOAD.
  - LOAD: serial_load=1 for CLK_DIV cycles, serial_clock=0 -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Bit order:
  - Each word is shifted MSB first.
  - Chain 1 word order: pad AREA1PADS-1 down to pad 0.
  - Chain 2 word order: pad TOTAL_PADS-1 down to pad AREA1PADS.
  - The shorter chain is prefixed with zero bits so both chains finish on the same bit.
- Latency: from xfer_start to done = 1 + CLK_DIV + N*CLK_DIV + CLK_DIV + 1 cycles.
  - Default: 1+4+988+4+1 = 998 cycles.
- Snapshot: the shadow is read live during SHIFT; this is safe because writes are blocked while busy.
- Bit counter width: clog2(N+1).
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at reset values. Chain contents are undefined; no load pulse is produced.

Optional Feature:
MPRJ_IO_CFG_AUTOSTART_EN
- Defined: one transfer launches automatically on the second cycle after reset release, with no xfer_start needed. Default words are pushed to the pads, and done pulses at the end as normal.
- Undefined: transfers start only on xfer_start.

Decomposition:
- Package mprj_io_cfg_pkg holds:
  - FSM state enum
  - CFG_DEFAULT (13'h0403)
  - the shift-length function max(a,b)*w
- One sub-module, mprj_io_cfg_clkgen: divider producing the serial_clock phase and bit-advance tick, with enable and synchronous restart.

Test Plan:
- Reset -> all outputs at stated reset values; cfg_rdata(any pad<38)=13'h0403; serial_resetn=1 one cycle after release.
- Write pad0=13'h1ABC, pad18=13'h0001, pad37=13'h1FFF, then xfer_start:
  - first chain-1 bits shifted are pad18 MSB..LSB (0000000000001); last 13 are 1101010111100
  - chain 2 begins with pad37 bits, all ones
  - exactly 247 rising serial_clock edges occur
  - done arrives 998 cycles after start
- Write during busy -> shadow unchanged, wr_err=1. err_clr -> wr_err=0. Same-cycle set and clear -> 0.
- cfg_addr=40 write -> wr_err=1; cfg_rdata=0.
- Reset pulse at bit 100 of SHIFT -> busy=0, no serial_load pulse; a new xfer_start completes normally.
- With MPRJ_IO_CFG_AUTOSTART_EN, no stimulus after reset -> done seen once, after 2+998 cycles. Without the macro, busy stays 0.
